// File: rtl/rptr_empty_if.sv
// rptr_empty_if: read-side FIFO pointer/status bus between the read
// controller (slave) and its consumer plus write-pointer synchronizer (master).
interface rptr_empty_if #(parameter int ASIZE = 4);
  logic             rinc;
  logic             rempty;
  logic             ralmost_empty;
  logic             runderflow;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rlevel;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   rq2_wptr;
  modport master(output rinc, rq2_wptr,
                 input rempty, ralmost_empty, runderflow, raddr, rlevel, rptr);
  modport slave(input rinc, rq2_wptr,
                output rempty, ralmost_empty, runderflow, raddr, rlevel, rptr);
endinterface

// File: rtl/rptr_empty.sv
// rptr_empty: read-domain pointer and empty/level/underflow status for an
// asynchronous FIFO; consumes the write pointer already synchronized to rclk.
module rptr_empty #(
  parameter int ASIZE     = 4,
  parameter int AE_THRESH = 2
) (
  input  logic       rclk,
  input  logic       rrst_n,
  rptr_empty_if.slave rif
);
  logic [ASIZE:0] rbin_q, rbin_d, rptr_q, rptr_d, rlevel_q, rlevel_d, wbin_s;
  logic           rempty_q, rempty_d, rae_q, rae_d, runder_q, runder_d;
  for (genvar i = 0; i <= ASIZE; i++) begin : g_g2b
    assign wbin_s[i] = ^rif.rq2_wptr[ASIZE:i];
  end
  // Empty and level both look at the next pointer so the last pop flags empty on its own edge.
  always_comb begin
    rbin_d   = rbin_q + (ASIZE+1)'(rif.rinc & ~rempty_q);
    rptr_d   = (rbin_d >> 1) ^ rbin_d;
    rempty_d = rptr_d == rif.rq2_wptr;
    rlevel_d = wbin_s - rbin_d;
    rae_d    = rlevel_d <= (ASIZE+1)'(AE_THRESH);
    runder_d = runder_q | (rif.rinc & rempty_q);
  end
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      runder_q <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      runder_q <= runder_d;
    end
  assign rif.raddr         = rbin_q[ASIZE-1:0];
  assign rif.rptr          = rptr_q;
  assign rif.rlevel        = rlevel_q;
  assign rif.rempty        = rempty_q;
  assign rif.ralmost_empty = rae_q;
  assign rif.runderflow    = runder_q;
endmodule

// File: tb/tb_rptr_empty.sv
// tb_rptr_empty: scoreboard bench; a write/pop counter model predicts every
// registered output after each rclk edge and after async reset.
module tb_rptr_empty;
  typedef struct {
    logic       e, ae, u;
    logic [4:0] lvl, ptr;
    logic [3:0] addr;
  } exp_t;
  logic rclk = 1'b0;
  logic rrst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [4:0] m_rbin;
  logic       m_empty, m_under;
  logic [4:0] w;
  rptr_empty_if #(.ASIZE(4)) rif();
  rptr_empty #(.ASIZE(4), .AE_THRESH(2)) dut(.rclk(rclk), .rrst_n(rrst_n), .rif(rif));
  always #5 rclk = ~rclk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic push_model(input logic [4:0] wp);
    exp_t x;
    x.e    = m_empty;
    x.lvl  = wp - m_rbin;
    x.ae   = x.lvl <= 5'd2;
    x.u    = m_under;
    x.ptr  = m_rbin ^ (m_rbin >> 1);
    x.addr = m_rbin[3:0];
    sb.push_back(x);
  endtask
  task automatic compare();
    exp_t x;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    x = sb.pop_front();
    check("rempty", rif.rempty, x.e);
    check("ralmost_empty", rif.ralmost_empty, x.ae);
    check("runderflow", rif.runderflow, x.u);
    check("rlevel", rif.rlevel, x.lvl);
    check("rptr", rif.rptr, x.ptr);
    check("raddr", rif.raddr, x.addr);
  endtask
  task automatic do_reset();
    rrst_n = 1'b0;
    rif.rinc = 1'b0;
    rif.rq2_wptr = '0;
    m_rbin = '0;
    m_empty = 1'b1;
    m_under = 1'b0;
    #1;
    push_model(5'd0);
    compare();
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask
  task automatic step(input logic inc, input logic [4:0] wp);
    logic pop;
    @(negedge rclk);
    rif.rinc = inc;
    rif.rq2_wptr = wp ^ (wp >> 1);
    pop = inc & ~m_empty;
    m_under = m_under | (inc & m_empty);
    m_rbin = m_rbin + {4'd0, pop};
    m_empty = m_rbin == wp;
    push_model(wp);
    @(posedge rclk);
    #1;
    compare();
  endtask
  initial begin
    #2;
    do_reset();
    step(1'b1, 5'd0);
    step(1'b0, 5'd1);
    step(1'b0, 5'd2);
    step(1'b0, 5'd3);
    step(1'b0, 5'd3);
    step(1'b1, 5'd3);
    step(1'b1, 5'd3);
    step(1'b1, 5'd3);
    step(1'b1, 5'd3);
    w = 5'd3;
    for (int i = 0; i < 29; i++) begin
      w = w + 5'd1;
      step(1'b1, w);
    end
    for (int i = 0; i < 8; i++) step(1'b1, w);
    do_reset();
    step(1'b0, 5'd16);
    for (int i = 0; i < 17; i++) step(1'b1, 5'd16);
    do_reset();
    step(1'b1, 5'd0);
    step(1'b0, 5'd5);
    step(1'b0, 5'd5);
    do_reset();
    step(1'b0, 5'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
